// File: rtl/param_cache.sv
// Set-associative write-back line cache between a CPU port and a line-wide memory port.
// Tree-PLRU replacement per set; one outstanding request; all outputs registered.
//
// state     | meaning
// IDLE      | waiting for a CPU request; request registers load here
// COMPARE   | tag lookup; hit completes, miss picks and latches a victim
// WRITEBACK | dirty victim line being written to memory
// FILL      | requested line being read from memory into the victim way
module param_cache #(
  parameter int S_INDEX = 3,
  parameter int WAYS    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_byte_enable,
  input  logic [255:0] mem_wdata,
  output logic [255:0] mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int SETS    = 1 << S_INDEX;
  localparam int TW      = 27 - S_INDEX;
  localparam int LEVELS  = $clog2(WAYS);
  localparam int WW      = (WAYS > 1) ? LEVELS : 1;
  localparam int PLRU_W  = 8;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;

  state_t              state_q;
  logic [26:0]         req_line;
  logic [31:0]         req_be;
  logic [255:0]        req_wdata;
  logic                req_write;
  logic [WW-1:0]       victim_q;

  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     dirty_q [SETS];
  // Tree nodes in heap order (root 0, children 2n+1 / 2n+2); only WAYS-1 nodes are ever set.
  logic [PLRU_W-1:0]   plru_q  [SETS];
  logic [TW-1:0]       tag_q   [SETS][WAYS];
  logic [255:0]        data_q  [SETS][WAYS];

  logic [S_INDEX-1:0]  idx;
  logic [TW-1:0]       req_tag;
  logic                hit;
  logic                any_inv;
  logic [WW-1:0]       hit_way;
  logic [WW-1:0]       inv_way;
  logic [WW-1:0]       victim;
  logic [255:0]        hit_line;
  logic [255:0]        merged;
  logic                unused_ok;

  assign idx       = req_line[S_INDEX-1:0];
  assign req_tag   = req_line[26:S_INDEX];
  assign unused_ok = ^mem_address[4:0];

  function automatic logic [2:0] plru_victim(input logic [PLRU_W-1:0] b);
    logic [2:0] node;
    logic [2:0] w;
    node = '0;
    w    = '0;
    for (int l = 0; l < LEVELS; l++) begin
      w    = {w[1:0], b[node]};
      node = {node[1:0], 1'b0} + 3'd1 + {2'b00, b[node]};
    end
    return w;
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] b, input logic [2:0] way);
    logic [2:0]        node;
    logic [2:0]        path;
    logic              dir;
    logic [PLRU_W-1:0] r;
    r    = b;
    node = '0;
    path = way << (3 - LEVELS);
    for (int l = 0; l < LEVELS; l++) begin
      dir     = path[2];
      r[node] = ~dir;
      node    = {node[1:0], 1'b0} + 3'd1 + {2'b00, dir};
      path    = {path[1:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    // Descending scan so the lowest-indexed invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid_q[idx][w]) begin
        any_inv = 1'b1;
        inv_way = WW'(w);
      end
    end
    victim   = any_inv ? inv_way : WW'(plru_victim(plru_q[idx]));
    hit_line = data_q[idx][hit_way];
    merged   = hit_line;
    for (int i = 0; i < 32; i++) begin
      if (req_be[i]) merged[8*i +: 8] = req_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_line     <= '0;
      req_be       <= '0;
      req_wdata    <= '0;
      req_write    <= 1'b0;
      victim_q     <= '0;
      mem_resp     <= 1'b0;
      mem_rdata    <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
      case (state_q)
        IDLE: begin
          // mem_resp still high means the CPU has not yet dropped the finished request.
          if ((mem_read || mem_write) && !mem_resp) begin
            req_line  <= mem_address[31:5];
            req_be    <= mem_byte_enable;
            req_wdata <= mem_wdata;
            req_write <= mem_write;
            state_q   <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            mem_resp    <= 1'b1;
            mem_rdata   <= req_write ? merged : hit_line;
            plru_q[idx] <= plru_touch(plru_q[idx], 3'(hit_way));
            if (req_write) dirty_q[idx][hit_way] <= 1'b1;
            state_q <= IDLE;
          end else begin
            victim_q <= victim;
            if (dirty_q[idx][victim]) begin
              pmem_write   <= 1'b1;
              pmem_address <= {tag_q[idx][victim], idx, 5'b0};
              pmem_wdata   <= data_q[idx][victim];
              state_q      <= WRITEBACK;
            end else begin
              pmem_read    <= 1'b1;
              pmem_address <= {req_line, 5'b0};
              state_q      <= FILL;
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
            pmem_address <= {req_line, 5'b0};
            state_q      <= FILL;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            pmem_read                <= 1'b0;
            valid_q[idx][victim_q]   <= 1'b1;
            dirty_q[idx][victim_q]   <= 1'b0;
            state_q                  <= COMPARE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == FILL && pmem_resp) begin
      data_q[idx][victim_q] <= pmem_rdata;
      tag_q[idx][victim_q]  <= req_tag;
    end else if (state_q == COMPARE && hit && req_write) begin
      data_q[idx][hit_way] <= merged;
    end
  end

endmodule

// File: tb/tb_param_cache.sv
// Directed bench for param_cache: a 2-way and a 4-way instance share stimulus (one selected at a time),
// a line memory model with fixed 3-cycle response, and scoreboards for CPU responses and memory traffic.
module tb_param_cache;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sel = 1'b0;
  logic         mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0]  mem_address = '0, mem_byte_enable = '0;
  logic [255:0] mem_wdata = '0;
  logic [255:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  logic [255:0] rdata2, rdata4, pwd2, pwd4;
  logic         resp2, resp4, pr2, pr4, pw2, pw4;
  logic [31:0]  pa2, pa4;

  logic [255:0] rdata, pwd;
  logic         resp, pr, pw;
  logic [31:0]  pa;
  assign rdata = sel ? rdata4 : rdata2;
  assign resp  = sel ? resp4  : resp2;
  assign pr    = sel ? pr4    : pr2;
  assign pw    = sel ? pw4    : pw2;
  assign pa    = sel ? pa4    : pa2;
  assign pwd   = sel ? pwd4   : pwd2;

  always #5 clk = ~clk;

  param_cache #(.S_INDEX(3), .WAYS(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .mem_read(mem_read & ~sel), .mem_write(mem_write & ~sel),
    .mem_address(mem_address), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(rdata2), .mem_resp(resp2),
    .pmem_read(pr2), .pmem_write(pw2), .pmem_address(pa2), .pmem_wdata(pwd2),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp & ~sel)
  );

  param_cache #(.S_INDEX(3), .WAYS(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .mem_read(mem_read & sel), .mem_write(mem_write & sel),
    .mem_address(mem_address), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(rdata4), .mem_resp(resp4),
    .pmem_read(pr4), .pmem_write(pw4), .pmem_address(pa4), .pmem_wdata(pwd4),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp & sel)
  );

  typedef struct {bit is_wr; logic [31:0] addr; logic [255:0] data;} pmem_exp_t;
  typedef struct {bit is_rd; logic [255:0] line;} cpu_exp_t;

  pmem_exp_t    pq[$];
  cpu_exp_t     sb[$];
  logic [255:0] shadow [logic [31:0]];
  logic [255:0] pm     [logic [31:0]];
  int           nchk = 0, nfail = 0;
  int           cnt = 0;
  logic [255:0] last_rdata;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] gen(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = a ^ (32'h1357_9BDF * (k + 1));
    return l;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : gen(a);
  endfunction

  task automatic exp_rd(input logic [31:0] a);
    pmem_exp_t e;
    e.is_wr = 1'b0; e.addr = a; e.data = '0;
    pq.push_back(e);
  endtask

  task automatic exp_wr(input logic [31:0] a);
    pmem_exp_t e;
    e.is_wr = 1'b1; e.addr = a; e.data = line_of(a);
    pq.push_back(e);
  endtask

  // Memory model: answers each strobe on the third falling edge it is seen.
  always @(negedge clk) begin
    pmem_exp_t e;
    if (rst) begin
      pmem_resp = 1'b0;
      cnt = 0;
    end else if (pmem_resp) begin
      pmem_resp = 1'b0;
      cnt = 0;
    end else if (pr || pw) begin
      cnt++;
      if (cnt == 3) begin
        pmem_resp = 1'b1;
        check("pmem_excl", {255'd0, pr & pw}, '0);
        check("pmem_expected", {255'd0, pq.size() != 0}, 256'd1);
        if (pq.size() != 0) begin
          e = pq.pop_front();
          check("pmem_kind", {254'd0, pr, pw}, e.is_wr ? 256'd1 : 256'd2);
          check("pmem_addr", {224'd0, pa}, {224'd0, e.addr});
          if (e.is_wr) check("pmem_wdata", pwd, e.data);
        end
        if (pw) pm[pa] = pwd;
        if (pr) pmem_rdata = pm.exists(pa) ? pm[pa] : gen(pa);
      end
    end
  end

  task automatic cpu(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] be,
                     input logic [255:0] wd, input int exp_lat);
    int n;
    logic [255:0] l;
    cpu_exp_t c;
    @(negedge clk);
    if (wr) begin
      l = line_of(addr);
      for (int i = 0; i < 32; i++) if (be[i]) l[8*i +: 8] = wd[8*i +: 8];
      shadow[addr] = l;
    end
    c.is_rd = !wr; c.line = line_of(addr);
    sb.push_back(c);
    mem_read = rd; mem_write = wr; mem_address = addr; mem_byte_enable = be; mem_wdata = wd;
    n = 0;
    while (n < 300) begin
      @(posedge clk); #1;
      n++;
      if (resp) break;
      if (n == 1) begin
        mem_address = addr ^ 32'h0000_0100;
        mem_wdata = ~wd;
        mem_byte_enable = ~be;
      end
    end
    check("mem_resp_seen", {255'd0, resp}, 256'd1);
    if (resp) begin
      c = sb.pop_front();
      last_rdata = rdata;
      if (c.is_rd) check("mem_rdata", rdata, c.line);
      if (exp_lat > 0) check("hit_latency", 256'(n), 256'(exp_lat));
    end
    mem_read = 1'b0; mem_write = 1'b0; mem_address = 32'hFFFF_FFE0;
    @(posedge clk); #1;
    check("resp_one_cycle", {255'd0, resp}, '0);
    check("rdata_zero_idle", rdata, '0);
    check("pmem_drained", 256'(pq.size()), '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] wdb, wdx, ref_line;
    wdb = {{7{32'h0BAD_F00D}}, 32'hDEAD_BEEF};
    wdx = {8{32'hC0FF_EE11}};

    repeat (3) @(posedge clk);
    #1;
    check("rst_resp2", {255'd0, resp2}, '0);
    check("rst_pread2", {255'd0, pr2}, '0);
    check("rst_pwrite2", {255'd0, pw2}, '0);
    check("rst_rdata2", rdata2, '0);
    check("rst_resp4", {255'd0, resp4}, '0);
    check("rst_pread4", {255'd0, pr4}, '0);
    @(negedge clk);
    rst = 1'b0;

    // 2-way: cold miss, hit, masked write, merged readback
    exp_rd(32'h40);  cpu(1, 0, 32'h40, '0, '0, 0);
    cpu(1, 0, 32'h40, '0, '0, 2);
    cpu(0, 1, 32'h40, 32'h0000_000F, wdb, 2);
    cpu(1, 0, 32'h40, '0, '0, 2);
    ref_line = gen(32'h40);
    check("be_low_bytes", {224'd0, last_rdata[31:0]}, {224'd0, 32'hDEAD_BEEF});
    check("be_high_bytes", {32'd0, last_rdata[255:32]}, {32'd0, ref_line[255:32]});

    // same set: clean fill into way 1, then evict dirty 0x40
    exp_rd(32'h140); cpu(1, 0, 32'h140, '0, '0, 0);
    exp_wr(32'h40);  exp_rd(32'h240); cpu(1, 0, 32'h240, '0, '0, 0);
    exp_rd(32'h40);  cpu(1, 0, 32'h40, '0, '0, 0);

    // read+write together on a hit behaves as a write and leaves the line dirty
    cpu(1, 1, 32'h240, 32'h0000_FF00, wdx, 2);
    exp_rd(32'h340); cpu(1, 0, 32'h340, '0, '0, 0);
    exp_wr(32'h240); exp_rd(32'h440); cpu(1, 0, 32'h440, '0, '0, 0);

    // reset during FILL abandons the fill
    @(negedge clk);
    mem_read = 1'b1; mem_address = 32'h80;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (pr) break;
    end
    check("fill_started", {255'd0, pr}, 256'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_drops_pread", {255'd0, pr}, '0);
    check("rst_drops_resp", {255'd0, resp}, '0);
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_rd(32'h80);  cpu(1, 0, 32'h80, '0, '0, 0);
    exp_rd(32'h440); cpu(1, 0, 32'h440, '0, '0, 0);

    // 4-way: fill ways 0..3 dirty, re-touch way 0, miss evicts way 2
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_rd(32'(i) * 32'h100);
      cpu(0, 1, 32'(i) * 32'h100, 32'h0000_0001, {32{8'(8'h30 + i)}}, 0);
    end
    cpu(1, 0, 32'h000, '0, '0, 2);
    exp_wr(32'h200); exp_rd(32'h400); cpu(1, 0, 32'h400, '0, '0, 0);
    exp_wr(32'h100); exp_rd(32'h200); cpu(1, 0, 32'h200, '0, '0, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
